// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one DDR2 controller user port among NREQ requesters,
// with read-tag FIFO for response routing. Define DDR_ARB_FIXED_PRIO_EN for strict priority (lowest index wins).
module ddr_port_arbiter #(
  parameter int NREQ      = 3,
  parameter int AW        = 30,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8,
  parameter int RD_DEPTH  = 4,
  localparam int GW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               mem_cmd_valid,
  input  logic               mem_cmd_ready,
  output logic               mem_cmd_we,
  output logic [AW-1:0]      mem_cmd_addr,
  output logic [DW-1:0]      mem_cmd_wdata,
  input  logic               mem_rd_valid,
  input  logic [DW-1:0]      mem_rd_data,
  output logic [GW-1:0]      grant_id,
  output logic               busy,
  output logic               rd_orphan
);

  localparam int PW = $clog2(RD_DEPTH);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_grant_id, w_grant_nxt;
  logic [GW-1:0]   r_last_grant, w_last_nxt;
  logic [GW-1:0]   w_pick;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [GW-1:0]   r_tag_mem [RD_DEPTH];
  logic [PW:0]     r_wr_ptr, r_rd_ptr;
  logic [NREQ-1:0] r_rsp_valid;
  logic [DW-1:0]   r_rsp_data;
  logic            r_rd_orphan;
  logic            w_empty, w_full, w_push, w_pop, w_xfer;
  logic            w_req_v, w_req_we;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

  // Next grantee; scanning in reverse lets the closest candidate overwrite the others.
  always_comb begin
    w_pick = r_last_grant;
`ifdef DDR_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) w_pick = GW'(i);
    end
`else
    for (int i = NREQ; i >= 1; i--) begin
      int idx;
      idx = (int'(r_last_grant) + i) % NREQ;
      if (req_valid[idx]) w_pick = GW'(idx);
    end
`endif
  end

  assign w_req_v       = req_valid[r_grant_id];
  assign w_req_we      = req_we[r_grant_id];
  assign mem_cmd_valid = (r_state == ST_GRANT) & w_req_v & ~(~w_req_we & w_full);
  assign mem_cmd_we    = w_req_we;
  assign mem_cmd_addr  = req_addr[int'(r_grant_id) * AW +: AW];
  assign mem_cmd_wdata = req_wdata[int'(r_grant_id) * DW +: DW];
  assign w_xfer        = mem_cmd_valid & mem_cmd_ready;
  assign w_push        = w_xfer & ~w_req_we;
  assign w_pop         = mem_rd_valid & ~w_empty;

  always_comb begin
    req_ready             = '0;
    req_ready[r_grant_id] = w_xfer;
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_id;
    w_last_nxt  = r_last_grant;
    w_count_nxt = r_count;
    case (r_state)
      ST_IDLE: begin
        if (|req_valid) begin
          w_grant_nxt = w_pick;
          w_count_nxt = '0;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (w_xfer) w_count_nxt = r_count + 1'b1;
        if ((w_xfer && (r_count == BURST_LAST)) || !w_req_v) begin
          w_last_nxt  = r_grant_id;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= GW'(NREQ - 1);
      r_count      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_count      <= w_count_nxt;
    end
  end

  // NOTE: the tag storage is tiny, so it is reset with the pointers rather than left uninitialised.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < RD_DEPTH; i++) r_tag_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_tag_mem[r_wr_ptr[PW-1:0]] <= r_grant_id;
        r_wr_ptr                    <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rd_orphan <= 1'b0;
    end else begin
      r_rsp_valid <= w_pop ? (NREQ'(1) << r_tag_mem[r_rd_ptr[PW-1:0]]) : '0;
      if (w_pop) r_rsp_data <= mem_rd_data;
      if (mem_rd_valid && w_empty) r_rd_orphan <= 1'b1;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign grant_id  = r_grant_id;
  assign rd_orphan = r_rd_orphan;
  assign busy      = (r_state == ST_GRANT) | ~w_empty;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed self-checking bench for ddr_port_arbiter (3 requesters, MAX_BURST=8, RD_DEPTH=4).
module tb_ddr_port_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 30;
  localparam int DW   = 32;
  localparam int GW   = 2;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NREQ-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0]      rsp_data, mem_cmd_wdata, mem_rd_data;
  logic               mem_cmd_valid, mem_cmd_ready, mem_cmd_we, mem_rd_valid;
  logic [AW-1:0]      mem_cmd_addr;
  logic [GW-1:0]      grant_id;
  logic               busy, rd_orphan;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ddr_port_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .grant_id(grant_id), .busy(busy), .rd_orphan(rd_orphan)
  );

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_cmd_ready = 1'b1; mem_rd_valid = 1'b0; mem_rd_data = '0;
    cyc(); cyc(); #1;
    n_checks++; if (rsp_valid !== 3'b000) begin n_errors++; $display("FAIL reset_rsp_valid got %b exp 000", rsp_valid); end
    n_checks++; if (grant_id !== 2'd0) begin n_errors++; $display("FAIL reset_grant_id got %0d exp 0", grant_id); end
    n_checks++; if (rd_orphan !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL reset_flags got orphan=%b busy=%b exp 0 0", rd_orphan, busy); end
    n_checks++; if (mem_cmd_valid !== 1'b0 || rsp_data !== 32'h0) begin n_errors++; $display("FAIL reset_cmd got valid=%b data=%h exp 0 0", mem_cmd_valid, rsp_data); end
    cyc(); reset_n = 1'b1;
  endtask

  task automatic test_rr_writes();
    int order[4] = '{0, 1, 2, 0};
    logic exp_v;
    int g;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW]  = AW'(32'h1000 * (i + 1));
      req_wdata[i*DW +: DW] = 32'hC0DE0000 + i;
    end
    cyc(); req_we = 3'b111; req_valid = 3'b111; #1;
    for (int k = 0; k < 36; k++) begin
      if (k > 0) begin cyc(); #1; end
      exp_v = (k % 9) != 0;
      g = order[k / 9];
      n_checks++;
      if (mem_cmd_valid !== exp_v) begin n_errors++; $display("FAIL rr_cmd_valid cyc %0d got %b exp %b", k, mem_cmd_valid, exp_v); end
      if (exp_v) begin
        n_checks++;
        if (grant_id !== GW'(g) || req_ready !== (3'b001 << g)) begin
          n_errors++; $display("FAIL rr_grant cyc %0d got id=%0d ready=%b exp id=%0d", k, grant_id, req_ready, g);
        end
        n_checks++;
        if (mem_cmd_addr !== AW'(32'h1000 * (g + 1)) || mem_cmd_wdata !== 32'hC0DE0000 + g || mem_cmd_we !== 1'b1) begin
          n_errors++; $display("FAIL rr_payload cyc %0d got addr=%h data=%h exp req %0d", k, mem_cmd_addr, mem_cmd_wdata, g);
        end
      end
    end
    cyc(); req_valid = '0; #1;
    n_checks++; if (mem_cmd_valid !== 1'b0) begin n_errors++; $display("FAIL rr_end got %b exp 0", mem_cmd_valid); end
  endtask

  task automatic test_single_read();
    req_addr[1*AW +: AW] = 30'h100;
    cyc(); req_valid = 3'b010; req_we = 3'b000; #1;
    n_checks++; if (mem_cmd_valid !== 1'b0) begin n_errors++; $display("FAIL rd_latency got %b exp 0", mem_cmd_valid); end
    cyc(); #1;
    n_checks++;
    if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== 30'h100 || mem_cmd_we !== 1'b0 || req_ready !== 3'b010) begin
      n_errors++; $display("FAIL rd_cmd got valid=%b addr=%h we=%b ready=%b exp 1 100 0 010", mem_cmd_valid, mem_cmd_addr, mem_cmd_we, req_ready);
    end
    cyc(); req_valid = '0;
    cyc(); cyc(); #1;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rd_busy got %b exp 1", busy); end
    cyc(); cyc();
    mem_rd_valid = 1'b1; mem_rd_data = 32'hDEADBEEF; #1;
    n_checks++; if (rsp_valid !== 3'b000) begin n_errors++; $display("FAIL rd_early got %b exp 000", rsp_valid); end
    cyc(); mem_rd_valid = 1'b0; #1;
    n_checks++;
    if (rsp_valid !== 3'b010 || rsp_data !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL rd_rsp got %b %h exp 010 deadbeef", rsp_valid, rsp_data);
    end
    cyc(); #1;
    n_checks++;
    if (rsp_valid !== 3'b000 || rsp_data !== 32'hDEADBEEF || busy !== 1'b0) begin
      n_errors++; $display("FAIL rd_after got %b %h busy=%b exp 000 deadbeef 0", rsp_valid, rsp_data, busy);
    end
  endtask

  task automatic test_tag_full();
    int acc = 0;
    req_addr[2*AW +: AW] = 30'h2000;
    cyc(); req_valid = 3'b100; req_we = 3'b000; #1;
    for (int k = 1; k <= 6; k++) begin
      cyc(); #1;
      if (mem_cmd_valid && mem_cmd_ready) acc++;
      if (k >= 5) begin
        n_checks++;
        if (mem_cmd_valid !== 1'b0 || req_ready !== 3'b000) begin
          n_errors++; $display("FAIL full_stall cyc %0d got valid=%b ready=%b exp 0 000", k, mem_cmd_valid, req_ready);
        end
      end
    end
    n_checks++; if (acc !== 4) begin n_errors++; $display("FAIL full_accepted got %0d exp 4", acc); end
    cyc(); mem_rd_valid = 1'b1; mem_rd_data = 32'h11110000; #1;
    n_checks++; if (mem_cmd_valid !== 1'b0) begin n_errors++; $display("FAIL full_pop_cycle got %b exp 0", mem_cmd_valid); end
    cyc(); mem_rd_valid = 1'b0; #1;
    n_checks++;
    if (mem_cmd_valid !== 1'b1 || req_ready !== 3'b100 || rsp_valid !== 3'b100 || rsp_data !== 32'h11110000) begin
      n_errors++; $display("FAIL full_fifth got valid=%b ready=%b rsp=%b %h exp 1 100 100 11110000", mem_cmd_valid, req_ready, rsp_valid, rsp_data);
    end
    cyc(); #1;
    n_checks++; if (mem_cmd_valid !== 1'b0) begin n_errors++; $display("FAIL full_again got %b exp 0", mem_cmd_valid); end
    cyc(); req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      cyc(); mem_rd_valid = 1'b1; mem_rd_data = 32'hA0 + i;
      cyc(); mem_rd_valid = 1'b0; #1;
      n_checks++;
      if (rsp_valid !== 3'b100 || rsp_data !== 32'hA0 + i) begin
        n_errors++; $display("FAIL full_drain %0d got %b %h exp 100 %h", i, rsp_valid, rsp_data, 32'hA0 + i);
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL full_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_interleave();
    req_addr[0*AW +: AW] = 30'h200;
    req_addr[2*AW +: AW] = 30'h300;
    cyc(); req_valid = 3'b101; req_we = 3'b000;
    cyc(); #1;
    n_checks++;
    if (mem_cmd_valid !== 1'b1 || grant_id !== 2'd0 || mem_cmd_addr !== 30'h200) begin
      n_errors++; $display("FAIL il_first got valid=%b id=%0d addr=%h exp 1 0 200", mem_cmd_valid, grant_id, mem_cmd_addr);
    end
    cyc(); req_valid = 3'b100;
    cyc(); #1;
    n_checks++; if (mem_cmd_valid !== 1'b0) begin n_errors++; $display("FAIL il_gap got %b exp 0", mem_cmd_valid); end
    cyc(); #1;
    n_checks++;
    if (mem_cmd_valid !== 1'b1 || grant_id !== 2'd2 || mem_cmd_addr !== 30'h300) begin
      n_errors++; $display("FAIL il_second got valid=%b id=%0d addr=%h exp 1 2 300", mem_cmd_valid, grant_id, mem_cmd_addr);
    end
    cyc(); req_valid = '0;
    cyc(); mem_rd_valid = 1'b1; mem_rd_data = 32'hAAAA0000;
    cyc(); mem_rd_data = 32'hBBBB0000; #1;
    n_checks++;
    if (rsp_valid !== 3'b001 || rsp_data !== 32'hAAAA0000) begin
      n_errors++; $display("FAIL il_rsp0 got %b %h exp 001 aaaa0000", rsp_valid, rsp_data);
    end
    cyc(); mem_rd_valid = 1'b0; #1;
    n_checks++;
    if (rsp_valid !== 3'b100 || rsp_data !== 32'hBBBB0000) begin
      n_errors++; $display("FAIL il_rsp2 got %b %h exp 100 bbbb0000", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_orphan();
    cyc(); mem_rd_valid = 1'b1; mem_rd_data = 32'h55;
    cyc(); mem_rd_valid = 1'b0; #1;
    n_checks++;
    if (rsp_valid !== 3'b000 || rd_orphan !== 1'b1 || rsp_data !== 32'hBBBB0000) begin
      n_errors++; $display("FAIL orphan got rsp=%b orphan=%b data=%h exp 000 1 bbbb0000", rsp_valid, rd_orphan, rsp_data);
    end
    cyc(); cyc(); #1;
    n_checks++; if (rd_orphan !== 1'b1) begin n_errors++; $display("FAIL orphan_sticky got %b exp 1", rd_orphan); end
  endtask

  task automatic test_reset_mid_burst();
    req_addr[1*AW +: AW] = 30'h100;
    cyc(); req_valid = 3'b010; req_we = 3'b000;
    cyc();
    cyc(); req_valid = 3'b100; req_we = 3'b100;
    cyc(); cyc(); #1;
    n_checks++;
    if (mem_cmd_valid !== 1'b1 || grant_id !== 2'd2 || busy !== 1'b1) begin
      n_errors++; $display("FAIL mid_burst got valid=%b id=%0d busy=%b exp 1 2 1", mem_cmd_valid, grant_id, busy);
    end
    cyc(); reset_n = 1'b0; #1;
    n_checks++;
    if (mem_cmd_valid !== 1'b0 || req_ready !== 3'b000 || rsp_valid !== 3'b000 || rsp_data !== 32'h0 ||
        rd_orphan !== 1'b0 || grant_id !== 2'd0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL async_reset got valid=%b ready=%b rsp=%b orphan=%b id=%0d busy=%b exp all 0",
                           mem_cmd_valid, req_ready, rsp_valid, rd_orphan, grant_id, busy);
    end
    cyc(); reset_n = 1'b1; req_valid = '0;
    cyc(); mem_rd_valid = 1'b1; mem_rd_data = 32'h77;
    cyc(); mem_rd_valid = 1'b0; #1;
    n_checks++;
    if (rsp_valid !== 3'b000 || rd_orphan !== 1'b1) begin
      n_errors++; $display("FAIL reset_flush got rsp=%b orphan=%b exp 000 1", rsp_valid, rd_orphan);
    end
  endtask

  task automatic test_priority();
`ifdef DDR_ARB_FIXED_PRIO_EN
    int exp_g = 0;
`else
    int exp_g = 2;
`endif
    cyc(); reset_n = 1'b0;
    cyc(); reset_n = 1'b1;
    cyc(); req_valid = 3'b110; req_we = 3'b111; #1;
    for (int k = 1; k <= 11; k++) begin
      cyc();
      if (k == 2) req_valid = 3'b111;
      mem_cmd_ready = (k != 3);
      #1;
      if (k == 1) begin
        n_checks++; if (grant_id !== 2'd1) begin n_errors++; $display("FAIL prio_first got %0d exp 1", grant_id); end
      end
      if (k == 3) begin
        n_checks++;
        if (mem_cmd_valid !== 1'b1 || req_ready !== 3'b000) begin
          n_errors++; $display("FAIL prio_backpressure got valid=%b ready=%b exp 1 000", mem_cmd_valid, req_ready);
        end
      end
      if (k == 10) begin
        n_checks++; if (mem_cmd_valid !== 1'b0) begin n_errors++; $display("FAIL prio_gap got %b exp 0", mem_cmd_valid); end
      end
      if (k == 11) begin
        n_checks++;
        if (mem_cmd_valid !== 1'b1 || grant_id !== GW'(exp_g)) begin
          n_errors++; $display("FAIL prio_next got valid=%b id=%0d exp 1 %0d", mem_cmd_valid, grant_id, exp_g);
        end
      end
    end
    cyc(); req_valid = '0; mem_cmd_ready = 1'b1;
    cyc(); cyc();
  endtask

  initial begin
    test_reset();
    test_rr_writes();
    test_single_read();
    test_tag_full();
    test_interleave();
    test_orphan();
    test_reset_mid_burst();
    test_priority();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
